cbus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one cached-bus (CBus) master port among `NUM_INPUTS` requesters, such as the I-cache, D-cache and uncached path, ahead of the memory-side bus. Each grant is held until the downstream slave signals `oresp.last`. The next requester, other than the one just finishing, can be granted in that same cycle, so back-to-back transactions have no idle gap. Priority rotates on each completed transaction, so a continuously requesting input cannot starve the others.

---
 rtl/cbus_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one CBus master port among NUM_INPUTS requesters.
// A grant is held until the slave returns last. In that same cycle the next
// requester can be chosen, so back-to-back transactions have no idle gap.

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] scan_start;
  logic             scan_excl;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;

  // Successor of an index, wrapping from NUM_INPUTS-1 back to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(NUM_INPUTS - 1)) return '0;
    else                             return v + IDX_W'(1);
  endfunction

  // Scan origin: ptr while idle. On a handover it is the owner's successor,
  // and the finishing owner is skipped because its valid is still high.
  always_comb begin
    scan_start = ptr_q;
    scan_excl  = 1'b0;
    if (state_q == BUSY) begin
      scan_start = wrap_inc(owner_q);
      scan_excl  = 1'b1;
    end
  end

  // Round-robin pick: the first valid requester at or after scan_start.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand_idx = IDX_W'((int'(scan_start) + k) % NUM_INPUTS);
      if (!pick_found && ireqs[cand_idx].valid &&
          !(scan_excl && cand_idx == owner_q)) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: grant from idle, hand over or release on last.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          owner_d = pick_idx;
        end
      end
      BUSY: begin
        if (oresp.last) begin
          ptr_d = wrap_inc(owner_q);
          if (pick_found) owner_d = pick_idx;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Datapath: connect the owner to the slave while busy; everything else is zero.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) iresps[i] = '0;
    if (state_q == BUSY) begin
      oreq            = ireqs[owner_q];
      iresps[owner_q] = oresp;
    end
  end

  assign grant_valid = (state_q == BUSY);
  assign grant_idx   = owner_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter with three requesters. It uses a
// table of per-cycle vectors plus hand-written reset and stray-response sequences.

module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;
  localparam int W = 2;

  logic             clk = 1'b0;
  logic             reset;
  cbus_req_t        ireqs  [N];
  cbus_resp_t       iresps [N];
  cbus_req_t        oreq;
  cbus_resp_t       oresp;
  logic             grant_valid;
  logic [W-1:0]     grant_idx;

  int n_vec  = 0;
  int n_fail = 0;

  cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .ireqs       (ireqs),
    .iresps      (iresps),
    .oreq        (oreq),
    .oresp       (oresp),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [2:0] v;
    logic       rdy;
    logic       lst;
    logic       exp_gv;
    logic [1:0] exp_idx;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] v, input logic rdy, input logic lst,
                     input logic gv, input logic [1:0] idx, input string name);
    vec_t x;
    x.rst_n = r; x.v = v; x.rdy = rdy; x.lst = lst;
    x.exp_gv = gv; x.exp_idx = idx; x.name = name;
    vecs.push_back(x);
  endtask

  // Each requester has a distinct address, so oreq identifies its source.
  task automatic drive(input logic r, input logic [2:0] v, input logic rdy, input logic lst,
                       input logic [31:0] data);
    reset = r;
    for (int i = 0; i < N; i++) begin
      ireqs[i].valid    = v[i];
      ireqs[i].is_write = (i == 1);
      ireqs[i].addr     = 32'h1000 * (i + 1);
      ireqs[i].len      = 4'd4;
      ireqs[i].wdata    = 32'hA000_0000 + i;
    end
    oresp.ready = rdy;
    oresp.last  = lst;
    oresp.data  = data;
  endtask

  // Compare all outputs against the expected owner (gv/idx) and the stimulus currently driven.
  task automatic check_outputs(input string name, input logic gv, input logic [1:0] idx);
    cbus_req_t  exp_req;
    cbus_resp_t exp_resp;
    check({name, " grant_valid"}, 128'(grant_valid), 128'(gv));
    if (gv) check({name, " grant_idx"}, 128'(grant_idx), 128'(idx));
    exp_req = gv ? ireqs[idx] : '0;
    check({name, " oreq"}, 128'(oreq), 128'(exp_req));
    for (int i = 0; i < N; i++) begin
      exp_resp = (gv && idx == i) ? oresp : '0;
      check($sformatf("%s iresps[%0d]", name, i), 128'(iresps[i]), 128'(exp_resp));
    end
  endtask

  initial begin
    // Vector k: inputs held during cycle k; expected outputs reflect state before its closing edge.
    // Single request from input 1, 4 beats, last on beat 4.
    add(1, 3'b010, 0, 0, 0, 0, "single_req_idle");
    add(1, 3'b010, 1, 0, 1, 1, "single_beat1");
    add(1, 3'b010, 1, 0, 1, 1, "single_beat2");
    add(1, 3'b010, 1, 0, 1, 1, "single_beat3");
    add(1, 3'b010, 1, 1, 1, 1, "single_beat4_last");
    add(1, 3'b000, 0, 0, 0, 0, "single_after_last");
    // Reset so fairness starts from ptr 0, then all three contend with single-beat transfers.
    add(0, 3'b000, 0, 0, 0, 0, "fair_reset");
    add(1, 3'b111, 0, 0, 0, 0, "fair_req");
    add(1, 3'b111, 1, 1, 1, 0, "fair_g0");
    add(1, 3'b111, 1, 1, 1, 1, "fair_g1");
    add(1, 3'b111, 1, 1, 1, 2, "fair_g2");
    add(1, 3'b111, 1, 1, 1, 0, "fair_g0b");
    add(1, 3'b111, 1, 1, 1, 1, "fair_g1b");
    add(1, 3'b111, 1, 1, 1, 2, "fair_g2b");
    add(1, 3'b001, 1, 1, 1, 0, "fair_tail");
    add(1, 3'b000, 0, 0, 0, 0, "fair_idle");
    // Exclusion: input 0 alone re-requests right after last and gets one idle cycle.
    add(1, 3'b001, 0, 0, 0, 0, "excl_req");
    add(1, 3'b001, 1, 1, 1, 0, "excl_last");
    add(1, 3'b001, 0, 0, 0, 0, "excl_gap");
    add(1, 3'b001, 1, 1, 1, 0, "excl_regrant");
    // Wrap-around: serve 1 (ptr=2), then input 0 wins via wrap; ptr becomes 1 after it.
    add(1, 3'b010, 0, 0, 0, 0, "wrap_req1");
    add(1, 3'b010, 1, 1, 1, 1, "wrap_serve1");
    add(1, 3'b001, 0, 0, 0, 0, "wrap_req0");
    add(1, 3'b001, 1, 1, 1, 0, "wrap_serve0");
    add(1, 3'b110, 0, 0, 0, 0, "wrap_ptr1_req");
    add(1, 3'b110, 1, 1, 1, 1, "wrap_ptr1_g1");
    add(1, 3'b100, 1, 1, 1, 2, "wrap_ptr1_g2");
    // Reset mid-burst: input 2 at beat 2 of 8, then restart from input 0.
    add(1, 3'b100, 0, 0, 0, 0, "rst_req2");
    add(1, 3'b100, 1, 0, 1, 2, "rst_beat1");
    add(0, 3'b100, 1, 0, 1, 2, "rst_beat2");
    add(1, 3'b111, 1, 0, 0, 0, "rst_after");
    add(1, 3'b111, 1, 1, 1, 0, "rst_restart0");
    add(1, 3'b000, 1, 1, 1, 1, "rst_next1");
    add(1, 3'b000, 0, 0, 0, 0, "rst_idle");

    // Hold reset for two edges, then check the reset state.
    drive(0, 3'b000, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_outputs("reset_state", 1'b0, 2'd0);
    check("reset grant_idx", 128'(grant_idx), 128'(0));

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst_n, vecs[k].v, vecs[k].rdy, vecs[k].lst, 32'hD000_0000 + k);
      #1 check_outputs(vecs[k].name, vecs[k].exp_gv, vecs[k].exp_idx);
    end

    // Stray response while idle: no forwarding, no state change.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1, 3'b000, 1, 1, 32'hBEEF_0000 + c);
      #1 check_outputs("stray_idle", 1'b0, 2'd0);
    end
    // ptr is 2 after serving 1, so input 2 must win over 0 and the grant starts the next cycle.
    @(negedge clk);
    drive(1, 3'b101, 0, 0, 32'h0);
    #1 check_outputs("stray_req", 1'b0, 2'd0);
    @(negedge clk);
    drive(1, 3'b101, 1, 1, 32'h5555_0001);
    #1 check_outputs("stray_then_g2", 1'b1, 2'd2);
    @(negedge clk);
    drive(1, 3'b001, 1, 1, 32'h5555_0002);
    #1 check_outputs("stray_then_g0", 1'b1, 2'd0);
    @(negedge clk);
    drive(1, 3'b000, 0, 0, 32'h0);
    #1 check_outputs("stray_end_idle", 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
